// File: rtl/f_pc_gen.sv
// Fetch-stage PC generator: holds the fetch PC, redirects on exception/eret, and
// latches redirects that arrive during a stall. Define PC_RANGE_CHECK_EN to add text-range AdEL checks.
module f_pc_gen #(
   parameter int           W          = 32,
   parameter logic [W-1:0] RESET_PC   = W'(32'h0000_3000),
   parameter logic [W-1:0] HANDLER_PC = W'(32'h0000_4180),
   parameter logic [W-1:0] TEXT_LO    = W'(32'h0000_3000),
   parameter logic [W-1:0] TEXT_HI    = W'(32'h0000_6FFF)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic [W-1:0] npc,
   input  logic         exc_req,
   input  logic         eret_req,
   input  logic [W-1:0] epc,
   input  logic         imem_ready,
   output logic [W-1:0] pc,
   output logic         imem_req,
   output logic         fetch_valid,
   output logic         exc_adel,
   output logic         redirect_pending
);

   typedef enum logic {
      RUN  = 1'b0,
      PEND = 1'b1
   } state_t;

`ifdef PC_RANGE_CHECK_EN
   localparam bit RANGE_CHECK = 1'b1;
`else
   localparam bit RANGE_CHECK = 1'b0;
`endif

   state_t         state;
   logic [W-1:0]   pend_pc;
   logic           pend_kind;   // 1 = exception, 0 = eret
   logic           pend_valid;
   logic           advance;
   logic           range_fail;
   logic [W-1:0]   target;

   assign pend_valid = (state == PEND);

   // A pending redirect leaves PEND without waiting on the memory handshake.
   assign advance = en && (imem_ready || pend_valid);

   // NOTE: every signal written in always_comb gets a value on every path,
   // here via the final else, so no latch is inferred.
   always_comb begin
      if (exc_req)
         target = HANDLER_PC;
      else if (eret_req)
         target = epc;
      else if (pend_valid)
         target = pend_pc;
      else
         target = npc;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc        <= RESET_PC;
         pend_pc   <= RESET_PC;
         pend_kind <= 1'b0;
         state     <= RUN;
      end else if (advance) begin
         pc    <= target;
         state <= RUN;
      end else if (exc_req || eret_req) begin
         // An eret must not displace an exception already waiting.
         if (exc_req || !(pend_valid && pend_kind)) begin
            pend_pc   <= target;
            pend_kind <= exc_req;
            state     <= PEND;
         end
      end
   end

   assign range_fail = RANGE_CHECK && ((pc < TEXT_LO) || (pc > TEXT_HI));

   assign imem_req         = !pend_valid;
   assign redirect_pending = pend_valid;
   assign fetch_valid      = imem_ready && !pend_valid && !exc_req && !eret_req;
   assign exc_adel         = fetch_valid && ((pc[1:0] != 2'b00) || range_fail);

endmodule

// File: tb/tb_f_pc_gen.sv
// Scoreboard bench for f_pc_gen: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_f_pc_gen;

`ifdef PC_RANGE_CHECK_EN
   localparam bit RC = 1'b1;
`else
   localparam bit RC = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        en = 1'b1;
   logic [31:0] npc = 32'h0;
   logic        exc_req = 1'b0;
   logic        eret_req = 1'b0;
   logic [31:0] epc = 32'h0;
   logic        imem_ready = 1'b1;
   logic [31:0] pc;
   logic        imem_req;
   logic        fetch_valid;
   logic        exc_adel;
   logic        redirect_pending;

   typedef struct {
      string       name;
      logic [31:0] pc;
      logic        fv;
      logic        req;
      logic        rp;
      logic        adel;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   f_pc_gen dut (
      .clk(clk),
      .reset(reset),
      .en(en),
      .npc(npc),
      .exc_req(exc_req),
      .eret_req(eret_req),
      .epc(epc),
      .imem_ready(imem_ready),
      .pc(pc),
      .imem_req(imem_req),
      .fetch_valid(fetch_valid),
      .exc_adel(exc_adel),
      .redirect_pending(redirect_pending)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %h, want %h", name, act, want);
      end
   endtask

   // One cycle of stimulus: drive just after the edge, queue what the outputs must show.
   task automatic step(input logic rst, input logic e, input logic [31:0] n,
                       input logic x, input logic r, input logic [31:0] ep,
                       input logic rdy, input logic [31:0] xpc, input logic xfv,
                       input logic xreq, input logic xrp, input logic xadel,
                       input string name);
      exp_t ex;
      @(posedge clk);
      #1;
      reset      = rst;
      en         = e;
      npc        = n;
      exc_req    = x;
      eret_req   = r;
      epc        = ep;
      imem_ready = rdy;
      ex.name = name;
      ex.pc   = xpc;
      ex.fv   = xfv;
      ex.req  = xreq;
      ex.rp   = xrp;
      ex.adel = xadel;
      exp_q.push_back(ex);
   endtask

   // Monitor: compares whenever an expectation is outstanding, mid-cycle.
   initial begin
      exp_t ex;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            ex = exp_q.pop_front();
            check({ex.name, ".pc"},   pc,                       ex.pc);
            check({ex.name, ".fv"},   {31'b0, fetch_valid},      {31'b0, ex.fv});
            check({ex.name, ".req"},  {31'b0, imem_req},         {31'b0, ex.req});
            check({ex.name, ".rp"},   {31'b0, redirect_pending}, {31'b0, ex.rp});
            check({ex.name, ".adel"}, {31'b0, exc_adel},         {31'b0, ex.adel});
         end
      end
   end

   initial begin
      int waited;
      repeat (2) @(posedge clk);
      //   rst en npc           exc eret epc          rdy  pc            fv req rp adel name
      step(0, 1, 32'h0000_3004, 0, 0, 32'h0,        1, 32'h0000_3000, 1, 1, 0, 0, "reset");
      step(0, 1, 32'h0000_3008, 0, 0, 32'h0,        1, 32'h0000_3004, 1, 1, 0, 0, "seq1");
      step(0, 1, 32'h0000_300C, 0, 0, 32'h0,        0, 32'h0000_3008, 0, 1, 0, 0, "nordy1");
      step(0, 1, 32'h0000_300C, 0, 0, 32'h0,        0, 32'h0000_3008, 0, 1, 0, 0, "nordy2");
      step(0, 1, 32'h0000_300C, 0, 0, 32'h0,        1, 32'h0000_3008, 1, 1, 0, 0, "rdyback");
      step(0, 1, 32'h0000_3010, 0, 0, 32'h0,        1, 32'h0000_300C, 1, 1, 0, 0, "seq3");
      // Exception during a stall is latched and applied on the enabling edge.
      step(0, 0, 32'h0000_3014, 1, 0, 32'h0,        1, 32'h0000_3010, 0, 1, 0, 0, "stall_exc");
      step(0, 0, 32'h0000_3014, 0, 0, 32'h0,        1, 32'h0000_3010, 0, 0, 1, 0, "pend1");
      step(0, 0, 32'h0000_3014, 0, 0, 32'h0,        1, 32'h0000_3010, 0, 0, 1, 0, "pend2");
      step(0, 1, 32'h0000_3014, 0, 0, 32'h0,        0, 32'h0000_3010, 0, 0, 1, 0, "pend_rel");
      step(0, 1, 32'h0000_4184, 0, 0, 32'h0,        1, 32'h0000_4180, 1, 1, 0, 0, "handler");
      // eret then exception while stalled: exception wins.
      step(0, 0, 32'h0000_4188, 0, 1, 32'h0000_3200, 1, 32'h0000_4184, 0, 1, 0, 0, "st_eret");
      step(0, 0, 32'h0000_4188, 1, 0, 32'h0,        1, 32'h0000_4184, 0, 0, 1, 0, "st_exc");
      step(0, 1, 32'h0000_4188, 0, 0, 32'h0,        0, 32'h0000_4184, 0, 0, 1, 0, "rel_a");
      step(0, 1, 32'h0000_4184, 0, 0, 32'h0,        1, 32'h0000_4180, 1, 1, 0, 0, "ord_a");
      // Exception then eret while stalled: the eret must not displace it.
      step(0, 0, 32'h0000_4188, 1, 0, 32'h0,        1, 32'h0000_4184, 0, 1, 0, 0, "st_exc2");
      step(0, 0, 32'h0000_4188, 0, 1, 32'h0000_3200, 1, 32'h0000_4184, 0, 0, 1, 0, "st_eret2");
      step(0, 1, 32'h0000_4188, 0, 0, 32'h0,        1, 32'h0000_4184, 0, 0, 1, 0, "rel_b");
      // Same-cycle exception and eret while advancing.
      step(0, 1, 32'h0000_4184, 1, 1, 32'h0000_3200, 1, 32'h0000_4180, 0, 1, 0, 0, "both");
      step(0, 1, 32'h0000_4184, 0, 1, 32'h0000_3002, 1, 32'h0000_4180, 0, 1, 0, 0, "eret_mis");
      step(0, 1, 32'h0000_7000, 0, 0, 32'h0,        1, 32'h0000_3002, 1, 1, 0, 1, "adel_mis");
      step(0, 1, 32'h0000_6FFC, 0, 0, 32'h0,        1, 32'h0000_7000, 1, 1, 0, RC, "adel_hi");
      step(0, 1, 32'h0000_3020, 0, 0, 32'h0,        1, 32'h0000_6FFC, 1, 1, 0, 0, "top_ok");
      // eret overwrites a pending eret.
      step(0, 0, 32'h0000_3024, 0, 1, 32'h0000_3100, 1, 32'h0000_3020, 0, 1, 0, 0, "eret_a");
      step(0, 0, 32'h0000_3024, 0, 1, 32'h0000_3104, 1, 32'h0000_3020, 0, 0, 1, 0, "eret_b");
      step(0, 1, 32'h0000_3024, 0, 0, 32'h0,        0, 32'h0000_3020, 0, 0, 1, 0, "rel_c");
      step(0, 1, 32'h0000_3108, 0, 0, 32'h0,        1, 32'h0000_3104, 1, 1, 0, 0, "eret_ow");
      // Reset while a redirect is pending.
      step(0, 0, 32'h0000_310C, 1, 0, 32'h0,        1, 32'h0000_3108, 0, 1, 0, 0, "pre_rst");
      step(1, 0, 32'h0000_310C, 0, 0, 32'h0,        1, 32'h0000_3108, 0, 0, 1, 0, "rst_pend");
      step(0, 0, 32'h0000_3004, 0, 0, 32'h0,        1, 32'h0000_3000, 1, 1, 0, 0, "post_rst");
      // Misaligned PC replaced by a same-cycle exception raises no AdEL.
      step(0, 1, 32'h0000_3001, 0, 0, 32'h0,        1, 32'h0000_3000, 1, 1, 0, 0, "to_mis");
      step(0, 1, 32'h0000_3005, 1, 0, 32'h0,        1, 32'h0000_3001, 0, 1, 0, 0, "mis_exc");
      step(0, 1, 32'h0000_4184, 0, 0, 32'h0,        1, 32'h0000_4180, 1, 1, 0, 0, "final");

      waited = 0;
      while (exp_q.size() > 0 && waited < 20) begin
         @(posedge clk);
         waited++;
      end
      if (exp_q.size() > 0) begin
         errors++;
         checks++;
         $display("FAIL drain: got %0d queued, want 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/f_pc_gen.md
Name: f_pc_gen

Overview:
Parametrised fetch-stage PC generator for the 5-stage MIPS pipeline with CP0 exceptions. It holds the fetch PC and drives instruction-memory requests through a ready handshake. It redirects to the exception handler or to EPC (eret). A redirect that arrives during a stall is latched and applied later, never dropped. It also flags fetch address errors (AdEL) for the instruction leaving F.

Parameters:
W, 32, address width
RESET_PC, 32'h0000_3000, PC after reset
HANDLER_PC, 32'h0000_4180, exception entry address
TEXT_LO, 32'h0000_3000, lowest legal fetch address
TEXT_HI, 32'h0000_6FFF, highest legal fetch address

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
en  in  1  pipeline advance enable from hazard unit (0 = F stalled)
npc  in  W  sequential/branch next PC from NPC logic
exc_req  in  1  exception taken this cycle (from CP0)
eret_req  in  1  eret in D this cycle
epc  in  W  CP0 EPC value
imem_ready  in  1  instruction memory returns word for pc this cycle
pc  out  W  current fetch PC (registered)
imem_req  out  1  fetch request for pc
fetch_valid  out  1  instruction at pc is correct-path and returned; F/D may capture
exc_adel  out  1  AdEL on fetch of pc
redirect_pending  out  1  latched redirect awaiting advance

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (reset), sampled on posedge clk.
- Reset state: pc=RESET_PC, pend_valid=0, pend_kind=0, state RUN. Same values in the cycle after reset is sampled, whether reset hits mid-stall or mid-pending.
- Reset outputs: imem_req=1, redirect_pending=0. fetch_valid and exc_adel follow the combinational rules below.
- States:
  - RUN (pend_valid=0).
  - PEND (pend_valid=1, pend_pc, pend_kind: 1=exception, 0=eret).
  - redirect_pending = pend_valid.
- Target mux, priority high to low: exc_req -> HANDLER_PC; eret_req -> epc; pend_valid -> pend_pc; else npc.
- advance = en && (imem_ready || pend_valid). The PEND state does not need the imem handshake to leave.
- On advance: pc <= target; pend_valid <= 0. Next state is RUN.
- When not advancing and (exc_req || eret_req):
  - Latch target into pend_pc; pend_valid <= 1.
  - pend_kind <= exc_req.
  - A new exception overwrites any pending entry.
  - An eret does not overwrite a pending exception.
  - An eret overwrites a pending eret.
- When not advancing with no request: pc, pend_* hold. One-cycle latency from advance to new pc.
- imem_req = !pend_valid. No fetch is issued for a PC known to be wrong-path.
- fetch_valid = imem_ready && !pend_valid && !exc_req && !eret_req. The wrong-path slot becomes a bubble.
- exc_adel = fetch_valid && (pc[1:0]!=0 || range_fail).
  - range_fail = pc<TEXT_LO || pc>TEXT_HI. Inclusive bounds.
  - Compare unsigned on full W bits; no wrap-around.
- exc_adel never asserts for a PC being replaced by a redirect in the same cycle.
- Simultaneous exc_req and eret_req: exception wins, eret ignored.
- Stall with no redirect: pc holds and imem_req stays 1. fetch_valid may be 1; F/D gating is by en.

Optional Feature:
Macro PC_RANGE_CHECK_EN.
- Defined: range_fail as above.
- Undefined: range_fail tied 0, so exc_adel covers misalignment only. TEXT_LO/TEXT_HI are then unused.

Test Plan:
- Reset release; en=1, imem_ready=1, npc=pc+4 for 3 cycles -> pc 3000, 3004, 3008, 300C; fetch_valid=1; exc_adel=0.
- imem_ready=0 for 2 cycles at pc=3008 -> pc holds 3008, fetch_valid=0; advances to 300C the cycle after ready returns.
- en=0, exc_req pulse at pc=3010, then en=1 two cycles later -> redirect_pending=1 and imem_req=0 while stalled; pc=4180 after the enabling edge; redirect_pending=0.
- Stalled: eret_req (epc=3200) then exc_req next cycle; release en -> pc=4180. Reverse order (exc then eret) also -> pc=4180.
- Same-cycle exc_req and eret_req, en=1 -> pc=4180, fetch_valid=0 that cycle.
- Error fetches:
  - Redirect epc=3002 via eret -> exc_adel=1 at pc=3002.
  - npc=7000 -> exc_adel=1 with PC_RANGE_CHECK_EN defined, 0 with it undefined.
  - pc=6FFC -> exc_adel=0 in both builds.
  - Reset asserted while PEND -> pc=3000, redirect_pending=0 next cycle.
